// File: rtl/exu_alu_arb.sv
// Arbitrates one EXU ALU between the issue pipe (req0) and a secondary source (req1).
// Define EXU_ALU_ARB_STATS_EN to add the grant/override statistics counters.
module exu_alu_arb #(
    parameter int OPW          = 24,
    parameter int TAGW         = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_LOCK     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            freeze,
    input  logic            flush,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [31:0]     req0_a,
    input  logic [31:0]     req0_b,
    input  logic [OPW-1:0]  req0_op,
    input  logic [TAGW-1:0] req0_tag,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_lock,
    input  logic [31:0]     req1_a,
    input  logic [31:0]     req1_b,
    input  logic [OPW-1:0]  req1_op,
    input  logic [TAGW-1:0] req1_tag,
    output logic            alu_valid,
    output logic            alu_enable,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [31:0]     alu_out,
    output logic [1:0]      rsp_valid,
    output logic [31:0]     rsp_data,
    output logic [TAGW-1:0] rsp_tag
`ifdef EXU_ALU_ARB_STATS_EN
    ,
    output logic [31:0]     gnt0_cnt,
    output logic [31:0]     gnt1_cnt,
    output logic [31:0]     force_cnt
`endif
);

    typedef struct packed {
        logic [31:0]     a;
        logic [31:0]     b;
        logic [OPW-1:0]  op;
        logic [TAGW-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {ARB, LOCK1, DRAIN} state_t;

    state_t      state, state_nx;
    logic [7:0]  starve_cnt, starve_nx;
    logic [3:0]  lock_cnt, lock_nx;
    logic [1:0]  vld, rdy, gnt;
    logic [1:0]  rsp_own;
    logic [TAGW-1:0] tag_q;
    logic        at_limit;
    req_t [1:0]  req;
    req_t        win;

    assign req[0]   = {req0_a, req0_b, req0_op, req0_tag};
    assign req[1]   = {req1_a, req1_b, req1_op, req1_tag};
    assign vld      = {req1_valid, req0_valid};
    assign at_limit = (starve_cnt == 8'(STARVE_LIMIT));

    always_comb begin
        rdy = '0;
        if (!(rst || freeze || flush)) begin
            case (state)
                ARB: begin
                    if (at_limit && vld[1]) rdy[1] = 1'b1;
                    else if (vld[0])        rdy[0] = 1'b1;
                    else                    rdy[1] = vld[1];
                end
                LOCK1:   rdy[1] = vld[1];
                default: rdy = '0;
            endcase
        end
    end

    assign gnt        = vld & rdy;
    assign req0_ready = rdy[0];
    assign req1_ready = rdy[1];
    assign win        = gnt[1] ? req[1] : req[0];

    assign alu_valid  = |gnt;
    assign alu_enable = |gnt;
    assign alu_a      = (|gnt) ? win.a  : '0;
    assign alu_b      = (|gnt) ? win.b  : '0;
    assign alu_op     = (|gnt) ? win.op : '0;

    always_comb begin
        state_nx  = state;
        lock_nx   = lock_cnt;
        starve_nx = starve_cnt;
        if (flush) begin
            state_nx  = DRAIN;
            lock_nx   = '0;
            starve_nx = '0;
        end else if (!freeze) begin
            case (state)
                ARB: begin
                    // A MAX_LOCK of 1 means the first locked grant is already the last.
                    if (gnt[1] && req1_lock && MAX_LOCK > 1) begin
                        state_nx = LOCK1;
                        lock_nx  = 4'd1;
                    end
                end
                LOCK1: begin
                    if (!vld[1]) begin
                        state_nx = ARB;
                        lock_nx  = '0;
                    end else if (gnt[1]) begin
                        if (!req1_lock || (lock_cnt + 4'd1 == 4'(MAX_LOCK))) begin
                            state_nx = ARB;
                            lock_nx  = '0;
                        end else begin
                            lock_nx  = lock_cnt + 4'd1;
                        end
                    end
                end
                default: state_nx = ARB;
            endcase
            // A req1 transfer (including the forced lock exit) resets the starvation window.
            if (gnt[1] || !vld[1]) starve_nx = '0;
            else if (!at_limit)    starve_nx = starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            starve_cnt <= '0;
            lock_cnt   <= '0;
            rsp_own    <= '0;
            tag_q      <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            lock_cnt   <= lock_nx;
            if (flush) begin
                rsp_own <= '0;
            end else if (!freeze) begin
                rsp_own <= gnt;
                if (|gnt) tag_q <= win.tag;
            end
        end
    end

    assign rsp_valid = (rst || freeze || flush) ? 2'b00 : rsp_own;
    assign rsp_data  = alu_out;
    assign rsp_tag   = tag_q;

`ifdef EXU_ALU_ARB_STATS_EN
    logic [1:0][31:0] gnt_cnt;
    logic             force_gnt;

    assign force_gnt = (state == ARB) && at_limit && gnt[1];

    for (genvar i = 0; i < 2; i++) begin : g_gcnt
        always_ff @(posedge clk) begin
            if (rst)                                      gnt_cnt[i] <= '0;
            else if (!freeze && gnt[i] && gnt_cnt[i] != '1) gnt_cnt[i] <= gnt_cnt[i] + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                      force_cnt <= '0;
        else if (!freeze && force_gnt && force_cnt != '1) force_cnt <= force_cnt + 32'd1;
    end

    assign gnt0_cnt = gnt_cnt[0];
    assign gnt1_cnt = gnt_cnt[1];
`endif

endmodule

// File: tb/tb_exu_alu_arb.sv
// Directed bench for exu_alu_arb: a small adding ALU registers the result one cycle after a grant.
module tb_exu_alu_arb;
    localparam int OPW = 24, TAGW = 4;

    logic            clk = 1'b0;
    logic            rst, freeze, flush;
    logic            req0_valid, req0_ready, req1_valid, req1_ready, req1_lock;
    logic [31:0]     req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]  req0_op, req1_op;
    logic [TAGW-1:0] req0_tag, req1_tag;
    logic            alu_valid, alu_enable;
    logic [31:0]     alu_a, alu_b, alu_out;
    logic [OPW-1:0]  alu_op;
    logic [1:0]      rsp_valid;
    logic [31:0]     rsp_data;
    logic [TAGW-1:0] rsp_tag;
`ifdef EXU_ALU_ARB_STATS_EN
    logic [31:0]     gnt0_cnt, gnt1_cnt, force_cnt;
`endif
    logic [31:0]     alu_q = '0;
    int              checks = 0, errors = 0;

    exu_alu_arb #(.OPW(OPW), .TAGW(TAGW), .STARVE_LIMIT(8), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lock(req1_lock),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_tag(req1_tag),
        .alu_valid(alu_valid), .alu_enable(alu_enable), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag)
`ifdef EXU_ALU_ARB_STATS_EN
        , .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt), .force_cnt(force_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Bench-side ALU: registered add, holds its result when not enabled.
    always @(posedge clk) if (alu_enable) alu_q <= alu_a + alu_b;
    assign alu_out = alu_q;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic r0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        req0_valid = v; req0_a = a; req0_b = b; req0_tag = t; req0_op = 24'h1;
    endtask

    task automatic r1(input logic v, input logic l, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        req1_valid = v; req1_lock = l; req1_a = a; req1_b = b; req1_tag = t; req1_op = 24'h2;
    endtask

    task automatic idle();
        r0(0, 0, 0, 0); r1(0, 0, 0, 0, 0); cyc();
    endtask

    initial begin
        rst = 1; freeze = 0; flush = 0;
        r0(1, 1, 1, 1); r1(1, 0, 2, 2, 2);
        cyc(); cyc();
        // reset: valids asserted but nothing may be granted
        smp();
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_aluv", alu_valid, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_tag", rsp_tag, 0);
        cyc();
        rst = 0; idle();

        // single requester
        r0(1, 5, 3, 2); smp();
        chk("s_aluv", alu_valid, 1);
        chk("s_alue", alu_enable, 1);
        chk("s_alua", alu_a, 5);
        chk("s_alub", alu_b, 3);
        chk("s_op", alu_op, 24'h1);
        cyc(); r0(0, 0, 0, 0); smp();
        chk("s_rspv", rsp_valid, 2'b01);
        chk("s_data", rsp_data, 8);
        chk("s_tag", rsp_tag, 2);
        chk("s_idle_aluv", alu_valid, 0);
        chk("s_idle_alua", alu_a, 0);
        cyc(); idle();

        // contention and starvation override
        r0(1, 10, 1, 3); r1(1, 0, 20, 2, 4);
        for (int i = 0; i < 11; i++) begin
            smp();
            chk($sformatf("st_rdy0_%0d", i), req0_ready, (i != 8));
            chk($sformatf("st_rdy1_%0d", i), req1_ready, (i == 8));
            if (i == 9) begin
                chk("st_rsp1", rsp_valid, 2'b10);
                chk("st_rsp1_data", rsp_data, 22);
                chk("st_rsp1_tag", rsp_tag, 4);
            end
            cyc();
        end
`ifdef EXU_ALU_ARB_STATS_EN
        chk("st_force_cnt", force_cnt, 1);
`endif
        idle(); idle();

        // req1 lock: four back-to-back req1 grants, req0 locked out
        r1(1, 1, 7, 0, 6);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) r0(1, 1, 1, 1);
            smp();
            chk($sformatf("lk_rdy1_%0d", i), req1_ready, (i < 4));
            chk($sformatf("lk_rdy0_%0d", i), req0_ready, (i >= 4));
            if (i == 1) chk("lk_rsp", rsp_valid, 2'b10);
            cyc();
        end
        idle(); idle();

        // flush after a grant
        r0(1, 1, 1, 5); smp();
        chk("fl_gnt", alu_valid, 1);
        cyc(); flush = 1; smp();
        chk("fl_rdy_c", req0_ready, 0);
        chk("fl_aluv_c", alu_valid, 0);
        chk("fl_rspv_c", rsp_valid, 0);
        cyc(); flush = 0; smp();
        chk("fl_rdy_drain", req0_ready, 0);
        chk("fl_rspv_drain", rsp_valid, 0);
        cyc(); smp();
        chk("fl_rdy_after", req0_ready, 1);
        cyc(); r0(0, 0, 0, 0); smp();
        chk("fl_rsp_after", rsp_valid, 2'b01);
        cyc(); idle();

        // freeze holds an in-flight response
        r0(1, 10, 20, 7); smp();
        chk("fz_gnt", alu_valid, 1);
        cyc(); freeze = 1; r0(1, 3, 3, 8);
        for (int i = 0; i < 3; i++) begin
            smp();
            chk($sformatf("fz_rspv_%0d", i), rsp_valid, 0);
            chk($sformatf("fz_rdy_%0d", i), req0_ready, 0);
            cyc();
        end
        freeze = 0; r0(0, 0, 0, 0); smp();
        chk("fz_rspv", rsp_valid, 2'b01);
        chk("fz_tag", rsp_tag, 7);
        chk("fz_data", rsp_data, 30);
        cyc(); idle();

        // freeze and flush together: flush wins
        r0(1, 1, 2, 1); smp();
        chk("ff_gnt", alu_valid, 1);
        cyc(); freeze = 1; flush = 1; cyc();
        freeze = 0; flush = 0; smp();
        chk("ff_drain_rdy", req0_ready, 0);
        chk("ff_rspv", rsp_valid, 0);
        cyc(); idle();

        // reset discards an in-flight op
        r0(1, 9, 9, 3); smp();
        chk("rs_gnt", alu_valid, 1);
        cyc(); rst = 1; r0(0, 0, 0, 0); smp();
        chk("rs_rspv_c", rsp_valid, 0);
        cyc(); rst = 0; smp();
        chk("rs_rspv_n", rsp_valid, 0);
        cyc(); r0(1, 2, 2, 9); smp();
        chk("rs_rdy", req0_ready, 1);
        cyc(); r0(0, 0, 0, 0); smp();
        chk("rs_rsp", rsp_valid, 2'b01);
        chk("rs_data", rsp_data, 4);
        chk("rs_tag", rsp_tag, 9);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
